// File: rtl/des_decrypt_core_if.sv
// Request/result bundle between the byte assembler and the DES decrypt core.
// master: drives START/CIPHER/KEY, sees PLAIN/BUSY/DONE; slave is the core.
interface des_decrypt_core_if;
   logic        START;
   logic [64:1] CIPHER;
   logic [64:1] KEY;
   logic [64:1] PLAIN;
   logic        BUSY;
   logic        DONE;

   modport master (
      output START, CIPHER, KEY,
      input  PLAIN, BUSY, DONE
   );

   modport slave (
      input  START, CIPHER, KEY,
      output PLAIN, BUSY, DONE
   );
endinterface

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption, one Feistel round per clock, subkeys K16..K1.
// Ports: CLK, RST (async, active-low), bus (START/CIPHER/KEY in; PLAIN/BUSY/DONE out).
module des_decrypt_core (
   input logic               CLK,
   input logic               RST,
   des_decrypt_core_if.slave bus
);

   typedef enum logic {IDLE, ROUND} state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2,
      60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6,
      64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1,
      59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5,
      63, 55, 47, 39, 31, 23, 15,  7
   };

   localparam int FP_T [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32,
      39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30,
      37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28,
      35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26,
      33,  1, 41,  9, 49, 17, 57, 25
   };

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1
   };

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
   };

   state_t      state, state_nx;
   logic        load, last;
   logic [32:1] l_q, r_q;
   logic [28:1] c_q, d_q;
   logic [3:0]  cnt_q;
   logic [64:1] plain_q;
   logic        done_q;

   logic [64:1] ip_w;
   logic [56:1] pc1_w;
   logic [56:1] cd_w;
   logic [48:1] key_w;
   logic [48:1] e_w;
   logic [48:1] x_w;
   logic [32:1] s_w;
   logic [32:1] f_w;
   logic [64:1] pre_w;
   logic [64:1] fp_w;
   logic        rot1;
   logic [28:1] c_nx, d_nx;

   // Vectors are [N:1] with DES bit n at index N+1-n, so every table
   // entry t maps directly to source index N_src+1-t.
   for (genvar i = 1; i <= 64; i++) begin : g_ip
      assign ip_w[65-i] = bus.CIPHER[65-IP_T[i-1]];
      assign fp_w[65-i] = pre_w[65-FP_T[i-1]];
   end

   for (genvar i = 1; i <= 56; i++) begin : g_pc1
      assign pc1_w[57-i] = bus.KEY[65-PC1_T[i-1]];
   end

   assign cd_w = {c_q, d_q};

   for (genvar i = 1; i <= 48; i++) begin : g_pc2_e
      assign key_w[49-i] = cd_w[57-PC2_T[i-1]];
      assign e_w[49-i]   = r_q[33-E_T[i-1]];
   end

   assign x_w = e_w ^ key_w;

   // Row is the outer bit pair, column the inner four bits.
   for (genvar j = 0; j < 8; j++) begin : g_sbox
      logic [5:0] chunk;
      logic [5:0] idx;
      assign chunk = x_w[48-6*j -: 6];
      assign idx   = {chunk[5], chunk[0], chunk[4:1]};
      assign s_w[32-4*j -: 4] = 4'(SBOX[j][idx]);
   end

   for (genvar i = 1; i <= 32; i++) begin : g_p
      assign f_w[33-i] = s_w[33-P_T[i-1]];
   end

   // Preoutput swap: R16 is this round's new R, L16 is the current R.
   assign pre_w = {l_q ^ f_w, r_q};

   // Undo the encrypt-side left shifts of rounds 16..1.
   assign rot1 = (cnt_q == 4'd0) || (cnt_q == 4'd7) ||
                 (cnt_q == 4'd14) || (cnt_q == 4'd15);

   always_comb begin
      c_nx = {c_q[2:1], c_q[28:3]};
      d_nx = {d_q[2:1], d_q[28:3]};
      unique case (1'b1)
         rot1: begin
            c_nx = {c_q[1], c_q[28:2]};
            d_nx = {d_q[1], d_q[28:2]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.START) begin
               load     = 1'b1;
               state_nx = ROUND;
            end
         end
         ROUND: begin
            if (cnt_q == 4'd15) begin
               last     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         plain_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last;
         if (load) begin
            l_q   <= ip_w[64:33];
            r_q   <= ip_w[32:1];
            c_q   <= pc1_w[56:29];
            d_q   <= pc1_w[28:1];
            cnt_q <= '0;
         end else if (state == ROUND) begin
            l_q   <= r_q;
            r_q   <= l_q ^ f_w;
            c_q   <= c_nx;
            d_q   <= d_nx;
            cnt_q <= cnt_q + 4'd1;
            if (last) plain_q <= fp_w;
         end
      end
   end

   assign bus.PLAIN = plain_q;
   assign bus.BUSY  = (state == ROUND);
   assign bus.DONE  = done_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: FIPS vectors, timing, spam, abort.
// Drives the master side of des_decrypt_core_if; CLK period 10.
module tb_des_decrypt_core;

   logic CLK = 1'b0;
   logic RST;

   des_decrypt_core_if bus ();

   des_decrypt_core dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   localparam logic [64:1] K1 = 64'h133457799BBCDFF1;
   localparam logic [64:1] C1 = 64'h85E813540F0AB405;
   localparam logic [64:1] P1 = 64'h0123456789ABCDEF;
   localparam logic [64:1] K2 = 64'h0E329232EA6D0D73;
   localparam logic [64:1] C2 = 64'h0000000000000000;
   localparam logic [64:1] P2 = 64'h8787878787878787;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.DONE !== 1'b1 && n < max);
   endtask

   initial begin
      int n;
      int bad;
      int d_cnt;
      int d_at [2];
      int drop;
      int ov;

      RST        = 1'b0;
      bus.START  = 1'b1;
      bus.CIPHER = C1;
      bus.KEY    = K1;
      repeat (3) step();
      chk("reset_plain", bus.PLAIN, 64'd0);
      chk("reset_busy", 64'(bus.BUSY), 64'd0);
      chk("reset_done", 64'(bus.DONE), 64'd0);

      // First edge after release accepts the held START.
      RST = 1'b1;
      step();
      chk("e0_busy", 64'(bus.BUSY), 64'd1);
      chk("e0_done", 64'(bus.DONE), 64'd0);
      bus.START  = 1'b0;
      bus.CIPHER = '1;
      bus.KEY    = '0;
      bad = 0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b1) bad++;
      end
      chk("run1_mid_flags", 64'(bad), 64'd0);
      step();
      chk("run1_e16_done", 64'(bus.DONE), 64'd1);
      chk("run1_e16_busy", 64'(bus.BUSY), 64'd0);
      chk("run1_plain", bus.PLAIN, P1);
      step();
      chk("run1_e17_done", 64'(bus.DONE), 64'd0);
      chk("run1_hold", bus.PLAIN, P1);

      // Back-to-back: restart in the DONE cycle.
      bus.START  = 1'b1;
      bus.CIPHER = C1;
      bus.KEY    = K1;
      step();
      bus.START = 1'b0;
      wait_done(20, n);
      chk("b2b_a_latency", 64'(n), 64'd16);
      chk("b2b_a_plain", bus.PLAIN, P1);
      bus.START  = 1'b1;
      bus.CIPHER = C2;
      bus.KEY    = K2;
      step();
      chk("b2b_b_busy", 64'(bus.BUSY), 64'd1);
      chk("b2b_b_done", 64'(bus.DONE), 64'd0);
      bus.START = 1'b0;
      wait_done(20, n);
      chk("b2b_b_latency", 64'(n), 64'd16);
      chk("b2b_b_plain", bus.PLAIN, P2);

      // START held for 40 cycles; cycle 0 is the accepting edge.
      bus.START  = 1'b1;
      bus.CIPHER = C1;
      bus.KEY    = K1;
      d_cnt = 0;
      d_at  = '{-1, -1};
      drop  = 0;
      ov    = 0;
      bad   = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (bus.DONE === 1'b1) begin
            if (d_cnt < 2) d_at[d_cnt] = c;
            d_cnt++;
            if (bus.PLAIN !== P1) bad++;
         end
         if (bus.DONE === 1'b1 && bus.BUSY === 1'b1) ov++;
         if (bus.DONE !== 1'b1 && bus.BUSY !== 1'b1) drop++;
      end
      chk("spam_done_count", 64'(d_cnt), 64'd2);
      chk("spam_done_first", 64'(d_at[0]), 64'd16);
      chk("spam_done_second", 64'(d_at[1]), 64'd33);
      chk("spam_busy_drop", 64'(drop), 64'd0);
      chk("spam_overlap", 64'(ov), 64'd0);
      chk("spam_plain", 64'(bad), 64'd0);
      bus.START = 1'b0;
      wait_done(20, n);
      chk("spam_tail_latency", 64'(n), 64'd11);
      chk("spam_tail_plain", bus.PLAIN, P1);

      // Abort at round 8 with an asynchronous reset pulse.
      bus.START = 1'b1;
      step();
      bus.START = 1'b0;
      repeat (8) step();
      RST = 1'b0;
      #2;
      chk("abort_plain", bus.PLAIN, 64'd0);
      chk("abort_busy", 64'(bus.BUSY), 64'd0);
      chk("abort_done", 64'(bus.DONE), 64'd0);
      RST = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) bad++;
      end
      chk("abort_no_done", 64'(bad), 64'd0);
      bus.START  = 1'b1;
      bus.CIPHER = C2;
      bus.KEY    = K2;
      step();
      bus.START = 1'b0;
      wait_done(20, n);
      chk("post_abort_latency", 64'(n), 64'd16);
      chk("post_abort_plain", bus.PLAIN, P2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
